// File: rtl/binary_to_bcd_encoder.sv
// binary_to_bcd_encoder: multi-cycle double-dabble converter from ALU result to display digits
// Ports: clock, reset (sync, active-high), start/busy/done handshake,
//        Value + AluOverflow in, Zero/Overflow/Units/Tens/Hundreds out (held until next done).
// Optional macro BCD_FAST_PATH_EN: values below 10 bypass the shift loop.
module binary_to_bcd_encoder #(
    parameter int WIDTH     = 9,
    parameter int MAX_VALUE = 299
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Value,
    input  logic             AluOverflow,
    output logic             busy,
    output logic             done,
    output logic             Zero,
    output logic             Overflow,
    output logic [3:0]       Units,
    output logic [3:0]       Tens,
    output logic [1:0]       Hundreds
);
    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
    state_t state, state_n;
    logic [WIDTH-1:0] val, shreg, shreg_n;
    logic ovf, out_of_range, fast;
    logic [11:0] scratch, adj, scratch_n;
    logic [CW-1:0] cnt;
    assign out_of_range = ovf || (val > MAX_V);
`ifdef BCD_FAST_PATH_EN
    localparam logic [WIDTH-1:0] TEN = WIDTH'(10);
    assign fast = !out_of_range && (val < TEN);
`else
    assign fast = 1'b0;
`endif
    assign busy = (state == CHECK) || (state == SHIFT);
    assign done = (state == DONE);
    // add-3 on every digit >= 5, then shift the whole scratch:binary pair left
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++)
            adj[4*i+:4] = (scratch[4*i+:4] >= 4'd5) ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
        {scratch_n, shreg_n} = {adj, shreg} << 1;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? CHECK : IDLE;
            CHECK:   state_n = (out_of_range || fast) ? DONE : SHIFT;
            SHIFT:   state_n = (cnt == CW'(1)) ? DONE : SHIFT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;
    always_ff @(posedge clock) begin
        if (reset) begin
            val      <= '0;
            ovf      <= 1'b0;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            Units    <= '0;
            Tens     <= '0;
            Hundreds <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    val <= Value;
                    ovf <= AluOverflow;
                end
                CHECK: if (out_of_range) begin
                    Overflow <= 1'b1;
                    Zero     <= 1'b0;
                    Units    <= '0;
                    Tens     <= '0;
                    Hundreds <= '0;
                end else if (fast) begin
                    Overflow <= 1'b0;
                    Zero     <= (val == '0);
                    Units    <= val[3:0];
                    Tens     <= '0;
                    Hundreds <= '0;
                end else begin
                    shreg   <= val;
                    scratch <= '0;
                    cnt     <= CW'(WIDTH);
                end
                SHIFT: begin
                    shreg   <= shreg_n;
                    scratch <= scratch_n;
                    cnt     <= cnt - CW'(1);
                    // last shift: publish the post-shift digits on the edge entering DONE
                    if (cnt == CW'(1)) begin
                        Overflow <= 1'b0;
                        Zero     <= (val == '0);
                        Units    <= scratch_n[3:0];
                        Tens     <= scratch_n[7:4];
                        Hundreds <= scratch_n[9:8];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_binary_to_bcd_encoder.sv
// tb_binary_to_bcd_encoder: directed self-checking bench with an arithmetic reference model
module tb_binary_to_bcd_encoder;
    localparam int WIDTH = 9;
    localparam int MAXV  = 299;
    logic clock = 1'b0;
    logic reset, start, AluOverflow;
    logic [WIDTH-1:0] Value;
    logic busy, done, Zero, Overflow;
    logic [3:0] Units, Tens;
    logic [1:0] Hundreds;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int m_cnt, c_v, e_u, e_t, e_h;
    bit m_busy, m_done, c_o, e_z, e_of;

    binary_to_bcd_encoder #(.WIDTH(WIDTH), .MAX_VALUE(MAXV)) dut (
        .clock(clock), .reset(reset), .start(start), .Value(Value),
        .AluOverflow(AluOverflow), .busy(busy), .done(done), .Zero(Zero),
        .Overflow(Overflow), .Units(Units), .Tens(Tens), .Hundreds(Hundreds)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: edges-to-done from the start edge, digits by division
    function automatic int lat_after_start(int v, bit o);
        if (o || v > MAXV) return 1;
`ifdef BCD_FAST_PATH_EN
        if (v < 10) return 1;
`endif
        return WIDTH + 1;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_cnt = 0;
            e_u = 0; e_t = 0; e_h = 0; e_z = 0; e_of = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0;
                m_done = 1;
                e_of = c_o || (c_v > MAXV);
                e_z  = !e_of && (c_v == 0);
                e_u  = e_of ? 0 : c_v % 10;
                e_t  = e_of ? 0 : (c_v / 10) % 10;
                e_h  = e_of ? 0 : c_v / 100;
            end
        end else if (start) begin
            c_v = int'(Value);
            c_o = AluOverflow;
            m_busy = 1;
            m_cnt = lat_after_start(c_v, c_o);
        end
    end

    always @(negedge clock) if (chk_en) begin
        chk("model_busy", busy, m_busy);
        chk("model_done", done, m_done);
        chk("model_zero", Zero, e_z);
        chk("model_overflow", Overflow, e_of);
        chk("model_units", Units, e_u);
        chk("model_tens", Tens, e_t);
        chk("model_hundreds", Hundreds, e_h);
    end

    // counts edges, the start edge being edge 1; k0 edges already elapsed
    task automatic wait_done(input int k0, output int n);
        int k = k0;
        while (k < 40) begin
            @(posedge clock);
            k++;
            #1;
            if (done) break;
        end
        if (!done) chk("done_timeout", 0, 1);
        n = k;
    endtask

    task automatic do_start(input logic [WIDTH-1:0] v, input logic o);
        repeat (2) @(negedge clock);
        start = 1; Value = v; AluOverflow = o;
        @(negedge clock);
        start = 0; Value = ~v; AluOverflow = ~o;
    endtask

    task automatic run_vec(input logic [WIDTH-1:0] v, input logic o, input int u, input int t,
                           input int h, input logic z, input logic of, input int lat);
        int n;
        do_start(v, o);
        wait_done(1, n);
`ifdef BCD_FAST_PATH_EN
        if (!o && v < 10) lat = 2;
`endif
        chk("latency", n, lat);
        chk("units", Units, u);
        chk("tens", Tens, t);
        chk("hundreds", Hundreds, h);
        chk("zero", Zero, z);
        chk("overflow", Overflow, of);
        chk("busy_in_done", busy, 0);
    endtask

    initial begin
        int n;
        reset = 1; start = 0; Value = '0; AluOverflow = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", Zero, 0);
        chk("rst_overflow", Overflow, 0);
        chk("rst_digits", {Hundreds, Tens, Units}, 0);
        @(negedge clock);
        reset = 0;
        chk_en = 1;
        run_vec(9'd0,   0, 0, 0, 0, 1, 0, 11);
        run_vec(9'd255, 0, 5, 5, 2, 0, 0, 11);
        run_vec(9'd299, 0, 9, 9, 2, 0, 0, 11);
        run_vec(9'd300, 0, 0, 0, 0, 0, 1, 2);
        run_vec(9'd7,   1, 0, 0, 0, 0, 1, 2);
        run_vec(9'd0,   1, 0, 0, 0, 0, 1, 2);
        run_vec(9'd9,   0, 9, 0, 0, 0, 0, 11);
        run_vec(9'd10,  0, 0, 1, 0, 0, 0, 11);
        run_vec(9'd100, 0, 0, 0, 1, 0, 0, 11);
        run_vec(9'd199, 0, 9, 9, 1, 0, 0, 11);
        run_vec(9'd511, 0, 0, 0, 0, 0, 1, 2);
        // second start mid-conversion is ignored; input changes after start are ignored
        repeat (2) @(negedge clock);
        start = 1; Value = 9'd123; AluOverflow = 0;
        @(negedge clock); start = 0; Value = 9'd400;
        @(negedge clock);
        @(negedge clock); start = 1; Value = 9'd45;
        @(negedge clock); start = 0; Value = 9'd300; AluOverflow = 1;
        wait_done(4, n);
        chk("ignore_latency", n, 11);
        chk("ignore_digits", {Hundreds, Tens, Units}, {2'd1, 4'd2, 4'd3});
        repeat (15) @(negedge clock);
        chk("ignore_no_second_done", done, 0);
        // reset in flight discards the conversion
        start = 1; Value = 9'd200; AluOverflow = 0;
        @(negedge clock); start = 0;
        repeat (3) @(negedge clock);
        reset = 1;
        @(negedge clock); reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_digits", {Hundreds, Tens, Units}, 0);
        repeat (15) @(negedge clock);
        chk("abort_no_done", done, 0);
        run_vec(9'd42, 0, 2, 4, 0, 0, 0, 11);
        repeat (5) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
